// File: rtl/keypad_loader_pkg.sv
// Shared types and constants for the countdown-timer keypad front end.
package timer_pkg;
  localparam int BCD_W = 4;
  localparam int KEY_W = 10;
  localparam int MAX_SEC_TENS_DEFAULT = 5;

  typedef enum logic [2:0] {IDLE, ENTRY, LOAD, RUN, PAUSE} state_t;
  typedef logic [BCD_W-1:0] bcd_t;
endpackage

// File: rtl/keypad_loader_if.sv
// Keypad/button inputs and counter-chain drive signals of the keypad loader.
interface keypad_loader_if;
  import timer_pkg::*;

  logic [KEY_W-1:0] keypad;
  logic             startn;
  logic             stopn;
  logic             zero;
  bcd_t             min_data;
  bcd_t             sect_data;
  bcd_t             seco_data;
  logic             loadn;
  logic             enable;
  logic             running;
  logic             err;

  modport master (
    output keypad, startn, stopn, zero,
    input  min_data, sect_data, seco_data, loadn, enable, running, err
  );

  modport slave (
    input  keypad, startn, stopn, zero,
    output min_data, sect_data, seco_data, loadn, enable, running, err
  );
endinterface

// File: rtl/keypad_loader_key_encoder.sv
// Key press detector: a single key appearing after an all-released sample
// produces one key_valid cycle with its decimal value in key_bcd.
module key_encoder
  import timer_pkg::*;
(
  input  logic             clock,
  input  logic             clearn,
  input  logic [KEY_W-1:0] keypad,
  output logic             key_valid,
  output bcd_t             key_bcd
);

  function automatic logic [KEY_W-1:0] bit_mask(input int b);
    logic [KEY_W-1:0] m;
    for (int i = 0; i < KEY_W; i++) begin
      m[i] = ((i >> b) & 1) != 0;
    end
    return m;
  endfunction

  logic [KEY_W-1:0] keypad_prev_reg;
  logic             one_hot;

  always_ff @(posedge clock) begin
    if (!clearn) keypad_prev_reg <= '0;
    else         keypad_prev_reg <= keypad;
  end

  assign one_hot   = (keypad != '0) && ((keypad & (keypad - 1'b1)) == '0);
  assign key_valid = one_hot && (keypad_prev_reg == '0);

  // Each BCD bit is the OR of the keys whose index has that bit set.
  for (genvar gi = 0; gi < BCD_W; gi++) begin : g_bcd
    assign key_bcd[gi] = |(keypad & bit_mask(gi));
  end

endmodule

// File: rtl/keypad_loader.sv
// Entry/load/run sequencer: buffers three BCD digits from the keypad and
// drives the load and count-enable controls of the countdown counter chain.
module keypad_loader
  import timer_pkg::*;
#(
  parameter int LOAD_CYCLES  = 1,
  parameter int MAX_SEC_TENS = MAX_SEC_TENS_DEFAULT
) (
  input  logic            clock,
  input  logic            clearn,
  keypad_loader_if.slave  bus
);

  localparam logic [1:0] LOAD_LAST = 2'(LOAD_CYCLES - 1);
  localparam bcd_t       TENS_MAX  = BCD_W'(MAX_SEC_TENS);

  logic   key_valid;
  bcd_t   key_bcd;
  logic   startn_prev_reg, stopn_prev_reg;
  logic   start_ev, stop_ev;
  state_t state_reg, state_next;
  bcd_t   min_reg, min_next, sect_reg, sect_next, seco_reg, seco_next;
  logic [1:0] load_cnt_reg, load_cnt_next;
  logic   err_reg, err_next;
  logic   buf_empty;

  key_encoder u_key_encoder (
    .clock     (clock),
    .clearn    (clearn),
    .keypad    (bus.keypad),
    .key_valid (key_valid),
    .key_bcd   (key_bcd)
  );

  assign start_ev  = startn_prev_reg & ~bus.startn;
  assign stop_ev   = stopn_prev_reg & ~bus.stopn;
  assign buf_empty = (min_reg == '0) && (sect_reg == '0) && (seco_reg == '0);

  always_ff @(posedge clock) begin
    if (!clearn) begin
      state_reg       <= IDLE;
      min_reg         <= '0;
      sect_reg        <= '0;
      seco_reg        <= '0;
      load_cnt_reg    <= '0;
      err_reg         <= 1'b0;
      startn_prev_reg <= 1'b1;
      stopn_prev_reg  <= 1'b1;
    end else begin
      state_reg       <= state_next;
      min_reg         <= min_next;
      sect_reg        <= sect_next;
      seco_reg        <= seco_next;
      load_cnt_reg    <= load_cnt_next;
      err_reg         <= err_next;
      startn_prev_reg <= bus.startn;
      stopn_prev_reg  <= bus.stopn;
    end
  end

  always_comb begin
    state_next    = state_reg;
    min_next      = min_reg;
    sect_next     = sect_reg;
    seco_next     = seco_reg;
    load_cnt_next = load_cnt_reg;
    err_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        // Buffer is already clear here, so a start can only be rejected.
        if (start_ev && !stop_ev) err_next = 1'b1;
        if (key_valid) begin
          min_next   = sect_reg;
          sect_next  = seco_reg;
          seco_next  = key_bcd;
          state_next = ENTRY;
        end
      end
      ENTRY: begin
        if (stop_ev) begin
          min_next   = '0;
          sect_next  = '0;
          seco_next  = '0;
          state_next = IDLE;
        end else if (start_ev) begin
          if (buf_empty || (sect_reg > TENS_MAX)) begin
            err_next = 1'b1;
          end else begin
            load_cnt_next = '0;
            state_next    = LOAD;
          end
        end else if (key_valid) begin
          min_next  = sect_reg;
          sect_next = seco_reg;
          seco_next = key_bcd;
        end
      end
      LOAD: begin
        if (load_cnt_reg == LOAD_LAST) state_next = RUN;
        else                           load_cnt_next = load_cnt_reg + 2'd1;
      end
      RUN: begin
        if (bus.zero) begin
          min_next   = '0;
          sect_next  = '0;
          seco_next  = '0;
          state_next = IDLE;
        end else if (stop_ev) begin
          state_next = PAUSE;
        end
      end
      PAUSE: begin
        if (stop_ev) begin
          min_next   = '0;
          sect_next  = '0;
          seco_next  = '0;
          state_next = IDLE;
        end else if (start_ev) begin
          state_next = RUN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Controls decode straight from the state register, so loadn and enable
  // are mutually exclusive by construction.
  assign bus.loadn     = (state_reg != LOAD);
  assign bus.enable    = (state_reg == RUN);
  assign bus.running   = (state_reg == RUN);
  assign bus.err       = err_reg;
  assign bus.min_data  = min_reg;
  assign bus.sect_data = sect_reg;
  assign bus.seco_data = seco_reg;

endmodule

// File: tb/tb_keypad_loader.sv
// Scoreboard bench: stimulus queues the expected output vector and cycle of
// every output change; per-DUT monitors compare each observed change.
module tb_keypad_loader;
  import timer_pkg::*;

  typedef struct {
    int          cyc;
    logic [15:0] vec;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic clearn1, clearn3;
  logic [9:0] kp [2];
  logic sn [2];
  logic tn [2];
  logic zr [2];

  keypad_loader_if if1();
  keypad_loader_if if3();

  assign if1.keypad = kp[0];
  assign if1.startn = sn[0];
  assign if1.stopn  = tn[0];
  assign if1.zero   = zr[0];
  assign if3.keypad = kp[1];
  assign if3.startn = sn[1];
  assign if3.stopn  = tn[1];
  assign if3.zero   = zr[1];

  keypad_loader #(.LOAD_CYCLES(1)) dut1 (.clock(clock), .clearn(clearn1), .bus(if1));
  keypad_loader #(.LOAD_CYCLES(3)) dut3 (.clock(clock), .clearn(clearn3), .bus(if3));

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  exp_t q1[$];
  exp_t q3[$];
  logic [15:0] last1 = 'x;
  logic [15:0] last3 = 'x;
  bit mon1 = 0;
  bit mon3 = 0;

  function automatic logic [15:0] mk(input int mn, input int st, input int so,
                                     input bit ld, input bit en, input bit rn, input bit er);
    return {4'(mn), 4'(st), 4'(so), ld, en, rn, er};
  endfunction

  task automatic expect_v(input int d, input int dly, input logic [15:0] v);
    exp_t e;
    e.cyc = cyc + dly;
    e.vec = v;
    if (d == 0) begin
      if (v !== last1) begin q1.push_back(e); last1 = v; end
    end else begin
      if (v !== last3) begin q3.push_back(e); last3 = v; end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic raw_key(input int d, input logic [9:0] v);
    kp[d] = v;
    repeat (3) tick();
    kp[d] = '0;
    repeat (2) tick();
  endtask

  // Press key k; digits afterwards are mn/st/so (ENTRY: idle controls).
  task automatic press(input int d, input int k, input int mn, input int st, input int so);
    logic [9:0] one;
    one = 10'd1;
    expect_v(d, 1, mk(mn, st, so, 1, 0, 0, 0));
    raw_key(d, one << k);
  endtask

  task automatic start_pulse(input int d);
    sn[d] = 1'b0;
    repeat (2) tick();
    sn[d] = 1'b1;
    repeat (2) tick();
  endtask

  task automatic stop_pulse(input int d);
    tn[d] = 1'b0;
    repeat (2) tick();
    tn[d] = 1'b1;
    repeat (2) tick();
  endtask

  task automatic err_start(input int d, input int mn, input int st, input int so);
    expect_v(d, 1, mk(mn, st, so, 1, 0, 0, 1));
    expect_v(d, 2, mk(mn, st, so, 1, 0, 0, 0));
    start_pulse(d);
  endtask

  always @(negedge clock) begin : m1
    logic [15:0] cur;
    logic [15:0] prev;
    bit have;
    exp_t e;
    if (mon1) begin
      cur = {if1.min_data, if1.sect_data, if1.seco_data, if1.loadn, if1.enable, if1.running, if1.err};
      vectors++;
      if (!cur[3] && cur[2]) begin
        miscompares++;
        $display("FAIL dut1 load_enable_overlap: loadn=0 enable=1 at cycle %0d", cyc);
      end
      if (!have || cur !== prev) begin
        vectors++;
        if (q1.size() == 0) begin
          miscompares++;
          $display("FAIL dut1 unexpected_change: got %h at cycle %0d, expected no change", cur, cyc);
        end else begin
          e = q1.pop_front();
          if (cur !== e.vec || cyc != e.cyc) begin
            miscompares++;
            $display("FAIL dut1 outputs: got %h at cycle %0d, expected %h at cycle %0d",
                     cur, cyc, e.vec, e.cyc);
          end
        end
      end
      prev = cur;
      have = 1;
    end
  end

  always @(negedge clock) begin : m3
    logic [15:0] cur;
    logic [15:0] prev;
    bit have;
    exp_t e;
    if (mon3) begin
      cur = {if3.min_data, if3.sect_data, if3.seco_data, if3.loadn, if3.enable, if3.running, if3.err};
      vectors++;
      if (!cur[3] && cur[2]) begin
        miscompares++;
        $display("FAIL dut3 load_enable_overlap: loadn=0 enable=1 at cycle %0d", cyc);
      end
      if (!have || cur !== prev) begin
        vectors++;
        if (q3.size() == 0) begin
          miscompares++;
          $display("FAIL dut3 unexpected_change: got %h at cycle %0d, expected no change", cur, cyc);
        end else begin
          e = q3.pop_front();
          if (cur !== e.vec || cyc != e.cyc) begin
            miscompares++;
            $display("FAIL dut3 outputs: got %h at cycle %0d, expected %h at cycle %0d",
                     cur, cyc, e.vec, e.cyc);
          end
        end
      end
      prev = cur;
      have = 1;
    end
  end

  initial begin
    clearn1 = 1'b0;
    clearn3 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      kp[i] = '0; sn[i] = 1'b1; tn[i] = 1'b1; zr[i] = 1'b0;
    end
    repeat (2) tick();
    clearn1 = 1'b1;
    expect_v(0, 0, mk(0, 0, 0, 1, 0, 0, 0));
    mon1 = 1;

    // Entry and shifting; a held key shifts once.
    press(0, 1, 0, 0, 1);
    press(0, 3, 0, 1, 3);
    press(0, 0, 1, 3, 0);
    press(0, 0, 3, 0, 0);
    press(0, 7, 0, 0, 7);
    press(0, 5, 0, 7, 5);
    err_start(0, 0, 7, 5);
    press(0, 2, 7, 5, 2);
    press(0, 5, 5, 2, 5);

    // Valid start: one load cycle then run.
    expect_v(0, 1, mk(5, 2, 5, 0, 0, 0, 0));
    expect_v(0, 2, mk(5, 2, 5, 1, 1, 1, 0));
    start_pulse(0);
    raw_key(0, 10'h008);
    expect_v(0, 1, mk(5, 2, 5, 1, 0, 0, 0));
    stop_pulse(0);
    raw_key(0, 10'h010);
    expect_v(0, 1, mk(5, 2, 5, 1, 1, 1, 0));
    start_pulse(0);
    expect_v(0, 1, mk(0, 0, 0, 1, 0, 0, 0));
    zr[0] = 1'b1;
    tick();
    zr[0] = 1'b0;
    repeat (2) tick();

    // Two keys together, then start from IDLE with an empty buffer.
    raw_key(0, 10'b0000000110);
    err_start(0, 0, 0, 0);

    // Start and stop together in ENTRY.
    press(0, 4, 0, 0, 4);
    press(0, 1, 0, 4, 1);
    expect_v(0, 1, mk(0, 0, 0, 1, 0, 0, 0));
    sn[0] = 1'b0; tn[0] = 1'b0;
    repeat (2) tick();
    sn[0] = 1'b1; tn[0] = 1'b1;
    repeat (4) tick();
    err_start(0, 0, 0, 0);

    // Boundaries: all-zero entry, tens 6 rejected, tens 5 accepted.
    press(0, 0, 0, 0, 0);
    err_start(0, 0, 0, 0);
    press(0, 6, 0, 0, 6);
    press(0, 0, 0, 6, 0);
    err_start(0, 0, 6, 0);
    press(0, 5, 6, 0, 5);
    press(0, 9, 0, 5, 9);
    expect_v(0, 1, mk(0, 5, 9, 0, 0, 0, 0));
    expect_v(0, 2, mk(0, 5, 9, 1, 1, 1, 0));
    start_pulse(0);
    expect_v(0, 1, mk(0, 5, 9, 1, 0, 0, 0));
    stop_pulse(0);
    expect_v(0, 1, mk(0, 0, 0, 1, 0, 0, 0));
    stop_pulse(0);

    // Three-cycle load, then reset in the middle of a load.
    clearn3 = 1'b1;
    expect_v(1, 0, mk(0, 0, 0, 1, 0, 0, 0));
    mon3 = 1;
    press(1, 1, 0, 0, 1);
    press(1, 2, 0, 1, 2);
    expect_v(1, 1, mk(0, 1, 2, 0, 0, 0, 0));
    expect_v(1, 4, mk(0, 1, 2, 1, 1, 1, 0));
    start_pulse(1);
    expect_v(1, 1, mk(0, 1, 2, 1, 0, 0, 0));
    stop_pulse(1);
    expect_v(1, 1, mk(0, 0, 0, 1, 0, 0, 0));
    stop_pulse(1);
    press(1, 4, 0, 0, 4);
    press(1, 8, 0, 4, 8);
    expect_v(1, 1, mk(0, 4, 8, 0, 0, 0, 0));
    sn[1] = 1'b0;
    repeat (2) tick();
    clearn3 = 1'b0;
    sn[1] = 1'b1;
    expect_v(1, 1, mk(0, 0, 0, 1, 0, 0, 0));
    tick();
    clearn3 = 1'b1;
    repeat (6) tick();

    vectors++;
    if (q1.size() != 0) begin
      miscompares++;
      $display("FAIL dut1 pending: %0d expected changes never seen, required 0", q1.size());
    end
    vectors++;
    if (q3.size() != 0) begin
      miscompares++;
      $display("FAIL dut3 pending: %0d expected changes never seen, required 0", q3.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
